// File: rtl/bldc_pkg.sv
// Shared types for the BLDC sensorless commutation path: FSM states, commutation
// codes and the floating-phase / post-crossing-level lookup.
package bldc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SEEK  = 2'd2,
    DELAY = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PH_A = 2'd0,
    PH_B = 2'd1,
    PH_C = 2'd2
  } phase_e;

  typedef struct packed {
    phase_e phase;
    logic   target;
  } float_t;

  localparam logic [2:0] COMM_OFF = 3'b000;
  localparam logic [2:0] COMM_AB  = 3'b001;
  localparam logic [2:0] COMM_AC  = 3'b010;
  localparam logic [2:0] COMM_BC  = 3'b011;
  localparam logic [2:0] COMM_BA  = 3'b100;
  localparam logic [2:0] COMM_CA  = 3'b101;
  localparam logic [2:0] COMM_CB  = 3'b110;

  function automatic float_t float_lookup(input logic [2:0] comm);
    float_t f;
    unique case (comm)
      COMM_AB: f = '{phase: PH_C, target: 1'b0};
      COMM_AC: f = '{phase: PH_B, target: 1'b1};
      COMM_BC: f = '{phase: PH_A, target: 1'b0};
      COMM_BA: f = '{phase: PH_C, target: 1'b1};
      COMM_CA: f = '{phase: PH_B, target: 1'b0};
      COMM_CB: f = '{phase: PH_A, target: 1'b1};
      default: f = '{phase: PH_A, target: 1'b0};
    endcase
    return f;
  endfunction

  function automatic logic [2:0] comm_next(input logic [2:0] comm);
    logic [2:0] n;
    unique case (comm)
      COMM_AB: n = COMM_AC;
      COMM_AC: n = COMM_BC;
      COMM_BC: n = COMM_BA;
      COMM_BA: n = COMM_CA;
      COMM_CA: n = COMM_CB;
      default: n = COMM_AB;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bldc_zcd_comm_if.sv
// Signal bundle between the zero-crossing/commutation block and its PWM/control side.
interface bldc_zcd_comm_if #(
  parameter int CNT_W = 16
);
  logic             pwm_middle_i;
  logic             cmp_a_i;
  logic             cmp_b_i;
  logic             cmp_c_i;
  logic             run_en_i;
  logic [2:0]       comm_o;
  logic             zc_o;
  logic [CNT_W-1:0] period_o;
  logic             stall_o;

  modport slave (
    input  pwm_middle_i, cmp_a_i, cmp_b_i, cmp_c_i, run_en_i,
    output comm_o, zc_o, period_o, stall_o
  );

  modport master (
    output pwm_middle_i, cmp_a_i, cmp_b_i, cmp_c_i, run_en_i,
    input  comm_o, zc_o, period_o, stall_o
  );
endinterface

// File: rtl/bldc_sync2.sv
// Two-flop synchronizer for an asynchronous comparator input.
module bldc_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

// File: rtl/bldc_zcd_comm.sv
// Sensorless back-EMF zero-crossing detector: filters the floating-phase comparator
// at PWM mid-pulse, waits half a ZC period, then advances the commutation code.
module bldc_zcd_comm
  import bldc_pkg::*;
#(
  parameter int               CNT_W      = 16,
  parameter int               FILT_N     = 2,
  parameter int               BLANK_CLKS = 100,
  parameter logic [CNT_W-1:0] TIMEOUT    = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bldc_zcd_comm_if.slave       bus
);
  localparam logic [CNT_W-1:0] BLANK_V = CNT_W'(BLANK_CLKS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [2:0]       FILT_V  = 3'(FILT_N);

  logic cmp_a_s, cmp_b_s, cmp_c_s;

  bldc_sync2 u_sync_a (.clk(clk), .rst_n(rst_n), .d_i(bus.cmp_a_i), .q_o(cmp_a_s));
  bldc_sync2 u_sync_b (.clk(clk), .rst_n(rst_n), .d_i(bus.cmp_b_i), .q_o(cmp_b_s));
  bldc_sync2 u_sync_c (.clk(clk), .rst_n(rst_n), .d_i(bus.cmp_c_i), .q_o(cmp_c_s));

  state_e           state_q, state_d;
  logic [2:0]       comm_q, comm_d;
  logic [2:0]       filt_q, filt_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [CNT_W-1:0] zcc_q, zcc_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             zc_q, zc_d;
  logic             stall_q, stall_d;
  logic             first_q, first_d;
  logic             mid_q, run_q;

  float_t flt;
  logic   sample, strobe, evaluate, hit, accept;

  assign flt    = float_lookup(comm_q);
  assign strobe = bus.pwm_middle_i & ~mid_q;

  always_comb begin
    sample = cmp_a_s;
    unique case (flt.phase)
      PH_A:    sample = cmp_a_s;
      PH_B:    sample = cmp_b_s;
      default: sample = cmp_c_s;
    endcase
  end

  // A strobe landing on the last BLANK cycle already counts towards the filter.
  assign evaluate = strobe && ((state_q == SEEK) || ((state_q == BLANK) && (step_q == BLANK_V)));
  assign hit      = (sample == flt.target);
  assign accept   = evaluate && hit && ((filt_q + 3'd1) == FILT_V);

  always_comb begin
    state_d  = state_q;
    comm_d   = comm_q;
    filt_d   = filt_q;
    dly_d    = dly_q;
    period_d = period_q;
    zc_d     = 1'b0;
    stall_d  = stall_q;
    first_d  = first_q;
    step_d   = (step_q == CNT_MAX) ? step_q : step_q + CNT_ONE;
    zcc_d    = (zcc_q == CNT_MAX) ? zcc_q : zcc_q + CNT_ONE;

    unique case (state_q)
      IDLE: begin
        comm_d = COMM_OFF;
        filt_d = '0;
        if (bus.run_en_i && !run_q && !stall_q) begin
          comm_d  = COMM_AB;
          step_d  = '0;
          first_d = 1'b1;
          state_d = BLANK;
        end
      end
      BLANK: begin
        if (step_q == BLANK_V) state_d = SEEK;
      end
      SEEK: begin
        if (!accept && (step_q == TIMEOUT)) begin
          stall_d = 1'b1;
          comm_d  = COMM_OFF;
          state_d = IDLE;
        end
      end
      DELAY: begin
        dly_d = dly_q - CNT_ONE;
        if (dly_q == '0) begin
          comm_d  = comm_next(comm_q);
          step_d  = '0;
          filt_d  = '0;
          state_d = BLANK;
        end
      end
    endcase

    if (evaluate) filt_d = hit ? filt_q + 3'd1 : 3'd0;

    // The first crossing after start has no previous ZC, so step_cnt stands in for the half period.
    if (accept) begin
      zc_d    = 1'b1;
      state_d = DELAY;
      if (first_q) begin
        dly_d = step_q;
      end else begin
        period_d = zcc_q;
        dly_d    = zcc_q >> 1;
      end
      zcc_d   = '0;
      first_d = 1'b0;
    end

    if (!bus.run_en_i) begin
      state_d  = IDLE;
      comm_d   = COMM_OFF;
      stall_d  = 1'b0;
      zc_d     = 1'b0;
      filt_d   = '0;
      period_d = period_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      comm_q   <= COMM_OFF;
      filt_q   <= '0;
      step_q   <= '0;
      zcc_q    <= '0;
      dly_q    <= '0;
      period_q <= '0;
      zc_q     <= 1'b0;
      stall_q  <= 1'b0;
      first_q  <= 1'b0;
      mid_q    <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      comm_q   <= comm_d;
      filt_q   <= filt_d;
      step_q   <= step_d;
      zcc_q    <= zcc_d;
      dly_q    <= dly_d;
      period_q <= period_d;
      zc_q     <= zc_d;
      stall_q  <= stall_d;
      first_q  <= first_d;
      mid_q    <= bus.pwm_middle_i;
      run_q    <= bus.run_en_i;
    end
  end

  assign bus.comm_o   = comm_q;
  assign bus.zc_o     = zc_q;
  assign bus.period_o = period_q;
  assign bus.stall_o  = stall_q;
endmodule

// File: tb/tb_bldc_zcd_comm.sv
// Directed bench for bldc_zcd_comm: drives a stepped ideal back-EMF pattern with
// explicit strobe timing and checks ZC, delay, period, stall and run_en behaviour.
`timescale 1ns/1ps
module tb_bldc_zcd_comm;
  localparam int          CNT_W = 16;
  localparam logic [15:0] TMO   = 16'd3000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  bldc_zcd_comm_if #(.CNT_W(CNT_W)) bus ();

  bldc_zcd_comm #(
    .CNT_W(CNT_W), .FILT_N(2), .BLANK_CLKS(100), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [2:0]  cur_code;
  logic        first_zc;
  int          prev_d;
  int          cur_d;
  logic [15:0] exp_period;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Floating phase (0=A,1=B,2=C) and post-crossing level for each commutation code.
  function automatic int fphase(input logic [2:0] c);
    case (c)
      3'b001, 3'b100: return 2;
      3'b010, 3'b101: return 1;
      default:        return 0;
    endcase
  endfunction

  function automatic logic ftarget(input logic [2:0] c);
    return (c == 3'b010) || (c == 3'b100) || (c == 3'b110);
  endfunction

  function automatic logic [2:0] fnext(input logic [2:0] c);
    case (c)
      3'b001:  return 3'b010;
      3'b010:  return 3'b011;
      3'b011:  return 3'b100;
      3'b100:  return 3'b101;
      3'b101:  return 3'b110;
      default: return 3'b001;
    endcase
  endfunction

  // Non-floating phases get the opposite level so a wrong phase select never crosses.
  task automatic set_cmp(input logic [2:0] c, input logic lvl);
    bus.cmp_a_i = (fphase(c) == 0) ? lvl : ~lvl;
    bus.cmp_b_i = (fphase(c) == 1) ? lvl : ~lvl;
    bus.cmp_c_i = (fphase(c) == 2) ? lvl : ~lvl;
  endtask

  // Starts just after a commutation edge; the crossing is accepted on edge a.
  // mode 0: clean crossing, 1: one-strobe glitch first, 2: crossing inside BLANK first.
  task automatic seek_step(input int a, input int mode);
    logic tgt;
    logic early;
    tgt   = ftarget(cur_code);
    early = 1'b0;
    set_cmp(cur_code, ~tgt);
    for (int t = 1; t <= a; t++) begin
      tick();
      if (t < a && bus.zc_o) early = 1'b1;
      if (mode == 2 && t == 10)     set_cmp(cur_code, tgt);
      if (mode == 2 && t == 30)     set_cmp(cur_code, ~tgt);
      if (mode == 1 && t == a - 30) set_cmp(cur_code, tgt);
      if (mode == 1 && t == a - 20) set_cmp(cur_code, ~tgt);
      if (t == a - 10)              set_cmp(cur_code, tgt);
      bus.pwm_middle_i = (t == a - 3) || (t == a - 1) ||
                         (mode == 1 && (t == a - 25 || t == a - 15)) ||
                         (mode == 2 && (t == 20 || t == 22));
    end
    chk($sformatf("zc_pulse_%0d", cur_code), bus.zc_o, 1'b1);
    chk($sformatf("zc_early_%0d", cur_code), early, 1'b0);
    if (first_zc) begin
      cur_d = a - 1;
    end else begin
      exp_period = 16'(prev_d + a);
      cur_d      = int'(exp_period >> 1);
    end
    chk($sformatf("period_%0d", cur_code), bus.period_o, exp_period);
    first_zc = 1'b0;
    prev_d   = cur_d;
  endtask

  task automatic delay_step();
    logic moved;
    moved = 1'b0;
    for (int t = 1; t <= cur_d; t++) begin
      tick();
      if (t == 1) chk($sformatf("zc_width_%0d", cur_code), bus.zc_o, 1'b0);
      if (bus.comm_o !== cur_code) moved = 1'b1;
    end
    chk($sformatf("comm_hold_%0d", cur_code), moved, 1'b0);
    tick();
    cur_code = fnext(cur_code);
    chk($sformatf("comm_adv_%0d", cur_code), bus.comm_o, cur_code);
  endtask

  initial begin
    logic bad;
    bus.pwm_middle_i = 1'b0;
    bus.cmp_a_i      = 1'b0;
    bus.cmp_b_i      = 1'b0;
    bus.cmp_c_i      = 1'b0;
    bus.run_en_i     = 1'b0;
    exp_period       = '0;
    prev_d           = 0;
    cur_d            = 0;
    first_zc         = 1'b1;
    cur_code         = 3'b001;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_comm", bus.comm_o, 3'b000);
    chk("rst_zc", bus.zc_o, 1'b0);
    chk("rst_period", bus.period_o, 16'd0);
    chk("rst_stall", bus.stall_o, 1'b0);

    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_comm", bus.comm_o, 3'b000);

    set_cmp(3'b001, 1'b1);
    bus.run_en_i = 1'b1;
    tick();
    chk("start_comm", bus.comm_o, 3'b001);

    // first ZC at step_cnt=400 -> D=400; then 2000-count periods -> D=1000
    seek_step(401, 0);  delay_step();
    seek_step(1600, 0); delay_step();
    seek_step(1000, 1); delay_step();
    seek_step(1000, 2); delay_step();
    seek_step(1000, 0); delay_step();
    seek_step(1000, 0); delay_step();
    seek_step(1000, 0);

    repeat (100) tick();
    bus.run_en_i = 1'b0;
    tick();
    chk("drop_comm", bus.comm_o, 3'b000);
    chk("drop_stall", bus.stall_o, 1'b0);
    bad = 1'b0;
    for (int t = 0; t < 1500; t++) begin
      tick();
      if (bus.comm_o !== 3'b000) bad = 1'b1;
    end
    chk("drop_quiet", bad, 1'b0);
    chk("drop_period_hold", bus.period_o, 16'd2000);

    bus.run_en_i = 1'b1;
    tick();
    chk("restart_comm", bus.comm_o, 3'b001);
    cur_code = 3'b001;
    set_cmp(cur_code, 1'b1);
    bad = 1'b0;
    for (int t = 1; t <= int'(TMO); t++) begin
      tick();
      bus.pwm_middle_i = (t % 50 == 0);
      if (bus.stall_o !== 1'b0 || bus.comm_o !== 3'b001 || bus.zc_o !== 1'b0) bad = 1'b1;
    end
    chk("pre_stall", bad, 1'b0);
    tick();
    bus.pwm_middle_i = 1'b0;
    chk("stall_flag", bus.stall_o, 1'b1);
    chk("stall_comm", bus.comm_o, 3'b000);
    repeat (20) tick();
    chk("stall_blocks", bus.comm_o, 3'b000);
    chk("stall_sticky", bus.stall_o, 1'b1);
    bus.run_en_i = 1'b0;
    tick();
    chk("stall_clear", bus.stall_o, 1'b0);
    bus.run_en_i = 1'b1;
    tick();
    chk("stall_restart_comm", bus.comm_o, 3'b001);
    chk("stall_restart_flag", bus.stall_o, 1'b0);

    repeat (5) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_comm", bus.comm_o, 3'b000);
    chk("arst_period", bus.period_o, 16'd0);
    chk("arst_stall", bus.stall_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/bldc_zcd_comm.md
Name: bldc_zcd_comm

Overview:
- Sensorless back-EMF zero-crossing detector and commutation sequencer for the BLDC drive.
- Samples the floating-phase comparator at the PWM mid-pulse strobe (pwm_middle from bldc_pwm).
- Filters the samples to detect a zero crossing, waits 30 electrical degrees (half the measured ZC-to-ZC period), then advances the 3-bit commutation code.
- comm_o drives bldc_pwm comm_i directly, closing the commutation loop in hardware.

Parameters:
- CNT_W, 16: width of the step/period/delay counters (clocks at 50 MHz).
- FILT_N, 2: consecutive matching samples required to accept a zero crossing (1..7).
- BLANK_CLKS, 100: clocks after each commutation during which samples are ignored (demagnetization).
- TIMEOUT, 16'hFFFF: clocks in SEEK without a zero crossing before stall is declared.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset, asynchronous, active-low
- pwm_middle_i  in  1  from bldc_pwm pwm_middle_o; synchronous to clk
- cmp_a_i  in  1  phase A back-EMF comparator; asynchronous
- cmp_b_i  in  1  phase B back-EMF comparator; asynchronous
- cmp_c_i  in  1  phase C back-EMF comparator; asynchronous
- run_en_i  in  1  1 = run closed loop; 0 = idle
- comm_o  out  3  commutation code to bldc_pwm comm_i
- zc_o  out  1  one-cycle pulse on an accepted zero crossing
- period_o  out  CNT_W  last ZC-to-ZC period in clocks
- stall_o  out  1  sticky timeout flag; cleared when run_en_i=0

Behaviour:
- Reset values: comm_o=0, zc_o=0, period_o=0, stall_o=0, state=IDLE, all counters 0.
- Comparator inputs: each passes a 2-flop synchronizer before use.
- Strobe: a sample event is the rising edge of pwm_middle_i, detected against a registered copy (1-cycle delay).
- Floating phase and post-crossing level, by comm code:
  - 001: C, target 0
  - 010: B, target 1
  - 011: A, target 0
  - 100: C, target 1
  - 101: B, target 0
  - 110: A, target 1
- Commutation sequence: 001→010→011→100→101→110→001.
- step_cnt: clears on each commutation and increments every cycle, saturating at all-ones.
- zc_cnt: counts clocks between accepted ZCs, saturating.
- State IDLE:
  - comm_o=0; filter counter cleared.
  - run_en_i rising (0→1 while in IDLE and stall_o=0) → comm_o=001, step_cnt=0, first-ZC flag set, go to BLANK.
- State BLANK:
  - Sample events are ignored.
  - When step_cnt reaches BLANK_CLKS → SEEK.
- State SEEK:
  - On each sample event: sample == target → filt_cnt+1; otherwise filt_cnt=0.
  - When filt_cnt reaches FILT_N: assert zc_o for 1 cycle and go to DELAY.
  - Delay load value D:
    - first ZC after start: D = step_cnt;
    - otherwise: period_o <= zc_cnt, D = zc_cnt>>1.
  - In all cases zc_cnt restarts at 0 and the first-ZC flag clears.
  - If step_cnt reaches TIMEOUT with no accepted ZC → stall_o=1, comm_o=0, go to IDLE.
- State DELAY:
  - Sample events are ignored.
  - dly_cnt decrements each cycle.
  - At the cycle where dly_cnt==0: comm_o advances, step_cnt=0, filt_cnt=0, go to BLANK.
  - The comm_o change is therefore visible D+1 clocks after the zc_o pulse; D=0 gives commutation 1 clock after zc_o.
- run_en_i=0 in any state: next edge goes to IDLE, comm_o=0, stall_o=0. period_o holds its value.
- stall_o=1 blocks restart until run_en_i has been low for at least one cycle.
- A sample event coinciding with BLANK→SEEK entry is evaluated; one coinciding with DELAY→BLANK is ignored.
- Asynchronous reset mid-operation returns every register to its reset value immediately.

Decomposition:
- Shared package bldc_pkg:
  - state encodings IDLE/BLANK/SEEK/DELAY (2 bits);
  - comm code constants COMM_AB..COMM_CB (001..110);
  - floating-phase/target lookup function.
- Sub-module bldc_sync2: 2-flop synchronizer, instantiated ×3 for cmp_a/b/c.

Test Plan:
- Reset → all outputs 0. Then run_en_i=1 → comm_o=001 after 1 clock; with cmp_c held 1, no zc_o.
- comm=001, BLANK done, cmp_c 1→0, two strobes → zc_o pulse. First ZC at step_cnt=400 gives D=400, so comm_o=010 exactly 401 clocks after zc_o.
- Ideal motor model, steady 2000-clock ZC spacing → period_o=2000; commutation 1001 clocks after each zc_o; full 6-step sequence wraps 110→001.
- Glitch: target level for one strobe, then opposite, then target ×2 → exactly one zc_o, on the last strobe.
- Strobes and a valid crossing inside the BLANK window (step_cnt<100) → ignored; the crossing is accepted only after BLANK.
- Comparators frozen → stall_o=1 and comm_o=0 at step_cnt=TIMEOUT. run_en_i toggled low→high → stall_o clears, restart at comm_o=001.
- run_en_i dropped mid-DELAY → comm_o=0 next clock, no further comm change.
